// File: rtl/store_port_arbiter.sv
// Two-requester arbiter for the D$ store port: zero-latency forwarding, lock until grant,
// fixed port 0 priority with a starvation counter that periodically forces a port 1 win.
package store_port_arbiter_pkg;
    typedef struct packed {
        logic [11:0] address_index;
        logic [19:0] address_tag;
        logic [31:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [3:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [31:0] data_rdata;
    } dcache_req_o_t;
endpackage

module store_port_arbiter
    import store_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t req_port_i [1:0],
    output dcache_req_o_t req_port_o [1:0],
    output dcache_req_i_t dcache_req_o,
    input  dcache_req_o_t dcache_rsp_i,
    output logic          busy_o,
    output logic [1:0]    dbg_state_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // Handshake: a request is forwarded while data_req is high; it completes in the
    // cycle the D$ raises data_gnt. An ungranted forward is held until grant or drop.

    logic [1:0]    state_q, w_state_d;
    logic [CW-1:0] cnt_q, w_cnt_d;
    logic          owner_q;
    logic          w_req0, w_req1;
    logic          w_sel, w_fwd, w_gnt;

    assign w_req0 = req_port_i[0].data_req;
    assign w_req1 = req_port_i[1].data_req;

    always_comb begin
        w_sel = 1'b0;
        w_fwd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req1 && (!w_req0 || cnt_q == MAX_CNT)) begin
                    w_sel = 1'b1;
                    w_fwd = 1'b1;
                end else if (w_req0) begin
                    w_fwd = 1'b1;
                end
            end
            ST_LOCK0: w_fwd = w_req0;
            ST_LOCK1: begin
                w_sel = 1'b1;
                w_fwd = w_req1;
            end
            default: ;
        endcase
    end

    // Selected port's fields pass straight through, including kill_req on a drop.
    always_comb begin
        dcache_req_o          = req_port_i[w_sel];
        dcache_req_o.data_req = w_fwd;
    end

    assign w_gnt = dcache_rsp_i.data_gnt & w_fwd;

    always_comb begin
        req_port_o[0].data_gnt    = w_gnt & ~w_sel;
        req_port_o[1].data_gnt    = w_gnt & w_sel;
        req_port_o[0].data_rvalid = dcache_rsp_i.data_rvalid & ~owner_q;
        req_port_o[1].data_rvalid = dcache_rsp_i.data_rvalid & owner_q;
        req_port_o[0].data_rdata  = owner_q ? 32'd0 : dcache_rsp_i.data_rdata;
        req_port_o[1].data_rdata  = owner_q ? dcache_rsp_i.data_rdata : 32'd0;
    end

    always_comb begin
        w_state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_fwd && !w_gnt) w_state_d = w_sel ? ST_LOCK1 : ST_LOCK0;
            ST_LOCK0,
            ST_LOCK1: if (w_gnt || !w_fwd) w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // Counts port 0 wins only while port 1 is actually waiting.
    always_comb begin
        w_cnt_d = cnt_q;
        if (!w_req1) begin
            w_cnt_d = '0;
        end else if (w_gnt) begin
            if (w_sel)                 w_cnt_d = '0;
            else if (cnt_q != MAX_CNT) w_cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= w_state_d;
            cnt_q   <= w_cnt_d;
            if (w_gnt) owner_q <= w_sel;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed bench for store_port_arbiter: priority, lock hold, starvation, routing, kill, reset.
module tb_store_port_arbiter;
    import store_port_arbiter_pkg::*;

    logic          clk;
    logic          rst_n;
    dcache_req_i_t req_port_i [1:0];
    dcache_req_o_t req_port_o [1:0];
    dcache_req_i_t dcache_req_o;
    dcache_req_o_t dcache_rsp_i;
    logic          busy_o;
    logic [1:0]    dbg_state_o;

    int n_checks;
    int n_fail;

    store_port_arbiter #(.MAX_BURST(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_port_i  (req_port_i),
        .req_port_o  (req_port_o),
        .dcache_req_o(dcache_req_o),
        .dcache_rsp_i(dcache_rsp_i),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic req, input logic [31:0] wd, input logic kill);
        req_port_i[p].address_index = wd[11:0];
        req_port_i[p].address_tag   = wd[31:12];
        req_port_i[p].data_wdata    = wd;
        req_port_i[p].data_req      = req;
        req_port_i[p].data_we       = req;
        req_port_i[p].data_be       = req ? 4'hf : 4'h0;
        req_port_i[p].data_size     = 2'd2;
        req_port_i[p].kill_req      = kill;
        req_port_i[p].tag_valid     = req;
    endtask

    task automatic set_rsp(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        dcache_rsp_i.data_gnt    = gnt;
        dcache_rsp_i.data_rvalid = rvalid;
        dcache_rsp_i.data_rdata  = rdata;
    endtask

    task automatic idle_inputs();
        set_req(0, 1'b0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 1'b0);
        set_rsp(1'b0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string tag, input logic g0, input logic g1);
        check_eq({tag, "_gnt0"}, {63'd0, req_port_o[0].data_gnt}, {63'd0, g0});
        check_eq({tag, "_gnt1"}, {63'd0, req_port_o[1].data_gnt}, {63'd0, g1});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check_eq("rst_busy",   {63'd0, busy_o}, 64'd0);
        check_eq("rst_req",    {63'd0, dcache_req_o.data_req}, 64'd0);
        check_eq("rst_state",  {62'd0, dbg_state_o}, 64'd0);
        check_eq("rst_cnt",    {61'd0, dut.cnt_q}, 64'd0);
        check_eq("rst_owner",  {63'd0, dut.owner_q}, 64'd0);
        check_grants("rst", 1'b0, 1'b0);
        check_eq("rst_rvalid0", {63'd0, req_port_o[0].data_rvalid}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Port 0 only, granted every cycle
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 32'hA000_0000 + i, 1'b0);
            set_rsp(1'b1, 1'b0, 32'd0);
            @(negedge clk);
            check_eq("p0_wdata", {32'd0, dcache_req_o.data_wdata}, {32'd0, 32'hA000_0000 + i});
            check_grants("p0", 1'b1, 1'b0);
            check_eq("p0_busy", {63'd0, busy_o}, 64'd0);
            check_eq("p0_cnt",  {61'd0, dut.cnt_q}, 64'd0);
            tick();
        end
        idle_inputs();
        tick();

        // Lock hold: port 0 forwarded ungranted, port 1 arrives later
        for (int c = 0; c < 5; c++) begin
            set_req(0, c < 4, 32'h0000_1111, 1'b0);
            set_req(1, c >= 1, 32'h0000_2222, 1'b0);
            set_rsp(c >= 3, 1'b0, 32'd0);
            @(negedge clk);
            check_eq("lk_req", {63'd0, dcache_req_o.data_req}, 64'd1);
            check_eq("lk_wdata", {32'd0, dcache_req_o.data_wdata},
                     (c < 4) ? 64'h1111 : 64'h2222);
            check_eq("lk_busy", {63'd0, busy_o}, {63'd0, (c >= 1 && c <= 3)});
            check_grants("lk", c == 3, c == 4);
            tick();
        end
        check_eq("lk_cnt_after", {61'd0, dut.cnt_q}, 64'd0);
        idle_inputs();
        tick();

        // Starvation: both request continuously, grant every cycle
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1'b1, 32'hB000_0000 + i, 1'b0);
            set_req(1, 1'b1, 32'hC000_0000 + i, 1'b0);
            set_rsp(1'b1, 1'b0, 32'd0);
            @(negedge clk);
            check_eq("sv_cnt", {61'd0, dut.cnt_q}, 64'(i % 5));
            check_grants("sv", (i % 5) != 4, (i % 5) == 4);
            check_eq("sv_wdata", {32'd0, dcache_req_o.data_wdata},
                     ((i % 5) == 4) ? {32'd0, 32'hC000_0000 + i} : {32'd0, 32'hB000_0000 + i});
            tick();
        end
        idle_inputs();
        tick();

        // Response routing follows the owner of the last grant
        set_req(1, 1'b1, 32'h0000_3333, 1'b0);
        set_rsp(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check_grants("rr0", 1'b0, 1'b1);
        tick();
        set_req(1, 1'b0, 32'd0, 1'b0);
        set_req(0, 1'b1, 32'h0000_4444, 1'b0);
        set_rsp(1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        check_grants("rr1", 1'b1, 1'b0);
        check_eq("rr1_owner",   {63'd0, dut.owner_q}, 64'd1);
        check_eq("rr1_rvalid1", {63'd0, req_port_o[1].data_rvalid}, 64'd1);
        check_eq("rr1_rdata1",  {32'd0, req_port_o[1].data_rdata}, 64'hDEAD_BEEF);
        check_eq("rr1_rvalid0", {63'd0, req_port_o[0].data_rvalid}, 64'd0);
        check_eq("rr1_rdata0",  {32'd0, req_port_o[0].data_rdata}, 64'd0);
        tick();
        set_req(0, 1'b0, 32'd0, 1'b0);
        set_rsp(1'b0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check_eq("rr2_rdata0",  {32'd0, req_port_o[0].data_rdata}, 64'h1234_5678);
        check_eq("rr2_rvalid1", {63'd0, req_port_o[1].data_rvalid}, 64'd0);
        tick();
        idle_inputs();
        tick();

        // Kill in lock: port 1 locked, then drops with kill_req while port 0 asks
        set_req(1, 1'b1, 32'h0000_5555, 1'b0);
        @(negedge clk);
        check_eq("kl_fwd1", {32'd0, dcache_req_o.data_wdata}, 64'h5555);
        tick();
        set_req(0, 1'b1, 32'h0000_6666, 1'b0);
        @(negedge clk);
        check_eq("kl_busy",  {63'd0, busy_o}, 64'd1);
        check_eq("kl_state", {62'd0, dbg_state_o}, 64'd2);
        check_eq("kl_hold",  {32'd0, dcache_req_o.data_wdata}, 64'h5555);
        tick();
        set_req(1, 1'b0, 32'h0000_5555, 1'b1);
        @(negedge clk);
        check_eq("kl_kill", {63'd0, dcache_req_o.kill_req}, 64'd1);
        check_eq("kl_req",  {63'd0, dcache_req_o.data_req}, 64'd0);
        check_grants("kl", 1'b0, 1'b0);
        tick();
        set_req(1, 1'b0, 32'd0, 1'b0);
        set_rsp(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check_eq("kl_idle_busy", {63'd0, busy_o}, 64'd0);
        check_eq("kl_idle_fwd",  {32'd0, dcache_req_o.data_wdata}, 64'h6666);
        check_grants("kl_idle", 1'b1, 1'b0);
        tick();
        idle_inputs();
        tick();

        // Reset mid-lock: build cnt=2, lock port 1, then assert reset asynchronously
        set_req(0, 1'b1, 32'h0000_7777, 1'b0);
        set_req(1, 1'b1, 32'h0000_8888, 1'b0);
        set_rsp(1'b1, 1'b0, 32'd0);
        tick();
        tick();
        set_req(0, 1'b0, 32'd0, 1'b0);
        set_rsp(1'b0, 1'b0, 32'd0);
        tick();
        @(negedge clk);
        check_eq("rm_busy_pre",  {63'd0, busy_o}, 64'd1);
        check_eq("rm_cnt_pre",   {61'd0, dut.cnt_q}, 64'd2);
        check_eq("rm_state_pre", {62'd0, dbg_state_o}, 64'd2);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_eq("rm_busy",  {63'd0, busy_o}, 64'd0);
        check_eq("rm_cnt",   {61'd0, dut.cnt_q}, 64'd0);
        check_eq("rm_state", {62'd0, dbg_state_o}, 64'd0);
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h0000_9999, 1'b0);
        set_rsp(1'b1, 1'b0, 32'd0);
        #1;
        check_eq("rm_after_req",   {63'd0, dcache_req_o.data_req}, 64'd1);
        check_eq("rm_after_wdata", {32'd0, dcache_req_o.data_wdata}, 64'h9999);
        check_grants("rm_after", 1'b1, 1'b0);
        tick();
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
